// File: rtl/wrap_tally_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wrap_tally_pkg
// Description : Shared constants, glyphs and display state type for the
//               wrap_tally arrival counter and its seven-segment decoder.
// Revision    : 1.0 - initial release
// ============================================================================
package wrap_tally_pkg;

    localparam int BCD_W = 4;

    // Segment glyphs in active-high form, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0   = 7'b0111111;
    localparam logic [6:0] SEG_1   = 7'b0000110;
    localparam logic [6:0] SEG_2   = 7'b1011011;
    localparam logic [6:0] SEG_3   = 7'b1001111;
    localparam logic [6:0] SEG_4   = 7'b1100110;
    localparam logic [6:0] SEG_5   = 7'b1101101;
    localparam logic [6:0] SEG_6   = 7'b1111101;
    localparam logic [6:0] SEG_7   = 7'b0000111;
    localparam logic [6:0] SEG_8   = 7'b1111111;
    localparam logic [6:0] SEG_9   = 7'b1101111;
    localparam logic [6:0] SEG_OFF = 7'b0000000;

    typedef enum logic [0:0] {
        LIVE   = 1'b0,
        FROZEN = 1'b1
    } disp_state_e;

    // Binary 0..99 to two packed BCD digits {tens, units}
    function automatic logic [2*BCD_W-1:0] to_bcd(input int value);
        logic [BCD_W-1:0] tens;
        logic [BCD_W-1:0] units;
        tens  = BCD_W'(value / 10);
        units = BCD_W'(value % 10);
        return {tens, units};
    endfunction

endpackage : wrap_tally_pkg
`default_nettype wire

// File: rtl/wrap_tally_seg7_decode.sv
`default_nettype none
// ============================================================================
// Module      : seg7_decode
// Description : Combinational BCD digit to seven-segment decoder with
//               selectable output polarity. Non-decimal codes blank the digit.
// Revision    : 1.0 - initial release
// ============================================================================
module seg7_decode
    import wrap_tally_pkg::*;
#(
    parameter bit HEX_ACTIVE_LOW = 1'b1
) (
    input  logic [BCD_W-1:0] bcd_i,
    output logic [6:0]       seg_o
);

    logic [6:0] seg_ah_w;

    // Glyph lookup in active-high form, then polarity applied once at the output
    always_comb begin
        seg_ah_w = SEG_OFF;
        case (bcd_i)
            4'd0:    seg_ah_w = SEG_0;
            4'd1:    seg_ah_w = SEG_1;
            4'd2:    seg_ah_w = SEG_2;
            4'd3:    seg_ah_w = SEG_3;
            4'd4:    seg_ah_w = SEG_4;
            4'd5:    seg_ah_w = SEG_5;
            4'd6:    seg_ah_w = SEG_6;
            4'd7:    seg_ah_w = SEG_7;
            4'd8:    seg_ah_w = SEG_8;
            4'd9:    seg_ah_w = SEG_9;
            default: seg_ah_w = SEG_OFF;
        endcase
        seg_o = HEX_ACTIVE_LOW ? ~seg_ah_w : seg_ah_w;
    end

endmodule : seg7_decode
`default_nettype wire

// File: rtl/wrap_tally.sv
`default_nettype none
// ============================================================================
// Module      : wrap_tally
// Description : Counts each new arrival of the upstream mod-10 counter at
//               zero in a wrapping 2-digit BCD tally, pulses OVF on wrap and
//               drives two seven-segment displays with a freeze control.
// Revision    : 1.0 - initial release
// ============================================================================
module wrap_tally
    import wrap_tally_pkg::*;
#(
    parameter bit HEX_ACTIVE_LOW = 1'b1,
    parameter int TALLY_MAX      = 99
) (
    input  logic       CLK,
    input  logic       R,
    input  logic       Y,
    input  logic       CLR,
    input  logic       HOLD,
    output logic [7:0] TALLY,
    output logic       OVF,
    output logic [6:0] HEX0,
    output logic [6:0] HEX1
);

    localparam logic [7:0] MAX_BCD   = to_bcd(TALLY_MAX);
    localparam logic [6:0] HEX_RESET = HEX_ACTIVE_LOW ? ~SEG_0 : SEG_0;

    logic        y_q;
    logic [7:0]  tally_q;
    logic [7:0]  tally_d;
    logic        ovf_q;
    logic        ovf_d;
    logic        evt;
    logic [6:0]  hex0_q;
    logic [6:0]  hex1_q;
    logic [6:0]  seg0_w;
    logic [6:0]  seg1_w;
    logic        hex_load;
    disp_state_e state_q;
    disp_state_e state_d;

    // Rising-edge detect on Y plus the prioritised tally next-state (CLR > wrap > increment)
    always_comb begin
        evt     = Y & ~y_q;
        tally_d = tally_q;
        ovf_d   = 1'b0;
        if (CLR) begin
            tally_d = 8'h00;
        end else if (evt) begin
            if (tally_q == MAX_BCD) begin
                tally_d = 8'h00;
                ovf_d   = 1'b1;
            end else if (tally_q[3:0] == 4'd9) begin
                tally_d[3:0] = 4'd0;
                tally_d[7:4] = tally_q[7:4] + 4'd1;
            end else begin
                tally_d[3:0] = tally_q[3:0] + 4'd1;
            end
        end
    end

    // Edge-detect history and tally registers; y_q resets high so the
    // upstream counter resetting into zero is not seen as an arrival
    always_ff @(posedge CLK) begin
        if (R) begin
            y_q     <= 1'b1;
            tally_q <= 8'h00;
            ovf_q   <= 1'b0;
        end else begin
            y_q     <= Y;
            tally_q <= tally_d;
            ovf_q   <= ovf_d;
        end
    end

    seg7_decode #(.HEX_ACTIVE_LOW(HEX_ACTIVE_LOW)) u_dec_units (
        .bcd_i (tally_q[3:0]),
        .seg_o (seg0_w)
    );

    seg7_decode #(.HEX_ACTIVE_LOW(HEX_ACTIVE_LOW)) u_dec_tens (
        .bcd_i (tally_q[7:4]),
        .seg_o (seg1_w)
    );

    // Display FSM: the HEX registers load on every edge whose next state is
    // LIVE, so a high HOLD sample never changes the display
    always_comb begin
        state_d  = state_q;
        hex_load = 1'b0;
        case (state_q)
            LIVE: begin
                if (HOLD) begin
                    state_d = FROZEN;
                end else begin
                    hex_load = 1'b1;
                end
            end
            FROZEN: begin
                if (!HOLD) begin
                    state_d  = LIVE;
                    hex_load = 1'b1;
                end
            end
            default: begin
                state_d = LIVE;
            end
        endcase
    end

    // Display state and HEX register stage
    always_ff @(posedge CLK) begin
        if (R) begin
            state_q <= LIVE;
            hex0_q  <= HEX_RESET;
            hex1_q  <= HEX_RESET;
        end else begin
            state_q <= state_d;
            if (hex_load) begin
                hex0_q <= seg0_w;
                hex1_q <= seg1_w;
            end
        end
    end

    assign TALLY = tally_q;
    assign OVF   = ovf_q;
    assign HEX0  = hex0_q;
    assign HEX1  = hex1_q;

endmodule : wrap_tally
`default_nettype wire

// File: doc/wrap_tally.md
Name: wrap_tally

Overview:
- Downstream consumer of the mod-10 up/down counter's terminal indicator Y (high while that counter sits in state 0).
- Detects each new arrival at zero and tallies arrivals in a 2-digit BCD counter (00-99, wrapping).
- Drives two DE1 seven-segment displays.
- Provides a display-freeze (HOLD) and a synchronous tally clear.

Parameters:
- HEX_ACTIVE_LOW, 1: 1 = segment outputs active-low (DE1 HEX), 0 = active-high.
- TALLY_MAX, 99: terminal tally value before wrap to 00. Legal range 1-99, BCD-coded internally.

Ports:
- CLK  in  1  system clock; all state updates on posedge.
- R  in  1  reset; synchronous, active-high.
- Y  in  1  zero indicator from the mod-10 counter; synchronous to CLK.
- CLR  in  1  synchronous tally clear, active-high, level.
- HOLD  in  1  freeze HEX outputs while high; tally keeps counting.
- TALLY  out  8  current tally, BCD: [7:4] tens, [3:0] units.
- OVF  out  1  one-cycle pulse when the tally wraps TALLY_MAX -> 00.
- HEX0  out  7  units digit segments {g,f,e,d,c,b,a}.
- HEX1  out  7  tens digit segments {g,f,e,d,c,b,a}.

Behaviour:
- Reset (R high at posedge) sets:
  - TALLY = 8'h00, OVF = 0.
  - y_d (registered copy of Y) = 1. This suppresses the false event caused by the upstream counter resetting into state 0.
  - HEX0/HEX1 = glyph "0": 7'b1000000 when active-low.
- R has priority over every other input. R asserted mid-count clears everything at that edge; there is no partial state.
- Event definition: evt = Y & ~y_d, evaluated combinationally. y_d <= Y every non-reset edge.
  - Y high for N consecutive cycles counts once.
  - Y pulsing high every other cycle counts every pulse.
- Tally update at posedge, in priority order:
  - R: reset, as above.
  - CLR: TALLY <= 00, OVF <= 0. A coincident evt is discarded.
  - evt and TALLY == TALLY_MAX: TALLY <= 00, OVF <= 1.
  - evt otherwise: BCD increment. Units 9 -> 0 with carry into tens; tens never exceed 9.
  - else: hold; OVF <= 0.
- Latency:
  - Y rising sampled at edge k -> TALLY updated at edge k.
  - HEX outputs reflect the new TALLY at edge k+1 (display register stage).
- HOLD:
  - While HOLD = 1, HEX registers keep their value; TALLY and OVF continue normally.
  - On HOLD falling, HEX shows the current TALLY one edge later.
  - CLR while HOLD = 1 clears TALLY but not the display.
- Segment decode:
  - Standard glyphs for 0-9.
  - Tens digit 0 is shown as "0" (no blanking).
  - Illegal BCD (unreachable) decodes to all segments off.
- Display state machine, two states:
  - LIVE (reset state): HEX <= decode(TALLY) each edge.
  - FROZEN: HEX unchanged.
  - Transitions: LIVE -> FROZEN when HOLD = 1; FROZEN -> LIVE when HOLD = 0.
  - Reset forces LIVE.

Decomposition:
- Shared package/include:
  - BCD digit width (4).
  - Segment glyph constants SEG_0..SEG_9 and SEG_OFF (active-high form; inversion applied per HEX_ACTIVE_LOW).
  - Display state encodings LIVE = 0, FROZEN = 1.
- One sub-module, seg7_decode: 4-bit BCD in, 7-bit segments out, HEX_ACTIVE_LOW parameter, purely combinational. Instantiated twice.

Test Plan:
- Reset with Y = 1 held, then release R with Y = 1 for 3 cycles -> TALLY stays 00, OVF never pulses, HEX0 = HEX1 = 7'b1000000.
- Y = 0 then pulse Y high 1 cycle, 12 times spaced 3 cycles apart -> TALLY = 8'h12. HEX1 = "1" (7'b1111001), HEX0 = "2" (7'b0100100), each one cycle after TALLY.
- Preload to 99 via 99 pulses, then one more pulse -> TALLY = 00 at the same edge, OVF high exactly 1 cycle, HEX shows 00 next edge.
- Y held high 5 cycles -> TALLY increments by exactly 1; Y toggling 1/0 for 8 cycles -> increments by 4.
- HOLD = 1 at TALLY = 05, then 3 events -> TALLY = 08 while HEX still shows 05. Drop HOLD -> HEX shows 08 one edge later.
- CLR coincident with an event at TALLY = 07 -> TALLY = 00, no OVF. R asserted mid-count at 34 -> all outputs at reset values next edge.
